// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_pkg                                                    |
// | Shared types for the parametrised accumulator processor: opcode     |
// | encodings, FSM states, ALU operation select and the opcode-to-ALU   |
// | mapping used by both the DECODE and EXEC paths.                     |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NOT   = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_LDI   = 4'hB,
    OP_JMP   = 4'hC,
    OP_JZ    = 4'hD,
    OP_JC    = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,  // result = b; carry is not meaningful
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8
  } alu_op_e;

  // LOAD and LDI both pass the b operand through; only the source of b
  // (MDR vs. immediate) differs, and that is chosen by the FSM state.
  function automatic alu_op_e alu_op_of(opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_acc_cpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : param_acc_cpu_if                                         |
// | Single shared instruction+data memory port between the core and    |
// | the memory. Names are from the core's point of view.                |
// |   i_memData     memory -> core  read data (valid when ready)        |
// |   i_memReady    memory -> core  request accepted/completed          |
// |   o_memData     core -> memory  write data                          |
// |   o_memAddr     core -> memory  request address                     |
// |   o_memWrEnable core -> memory  write request                       |
// |   o_memRdEnable core -> memory  read request                        |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface param_acc_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) ();

  logic [DATA_W-1:0] i_memData;
  logic              i_memReady;
  logic [DATA_W-1:0] o_memData;
  logic [ADDR_W-1:0] o_memAddr;
  logic              o_memWrEnable;
  logic              o_memRdEnable;

  modport master (
    input  i_memData,
    input  i_memReady,
    output o_memData,
    output o_memAddr,
    output o_memWrEnable,
    output o_memRdEnable
  );

  modport slave (
    output i_memData,
    output i_memReady,
    input  o_memData,
    input  o_memAddr,
    input  o_memWrEnable,
    input  o_memRdEnable
  );

endinterface
`default_nettype wire

// File: rtl/param_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : param_alu                                                   |
// | Combinational DATA_W-bit ALU for the accumulator core.              |
// |   a       in   DATA_W  accumulator operand                          |
// |   b       in   DATA_W  memory/immediate operand                     |
// |   op      in   alu_op_e operation select                            |
// |   result  out  DATA_W  wrapped result                               |
// |   carry   out  1       carry / borrow / shifted-out bit             |
// |   zero    out  1       result == 0                                  |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module param_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      ALU_SUB: begin
        // The extra top bit goes to 1 exactly when a < b (borrow).
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/param_acc_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : param_acc_cpu                                               |
// | Multicycle accumulator processor with one shared memory port,       |
// | ready handshake, Z/C flags, branches and a halt state.              |
// |   i_clk     in   1        clock                                     |
// |   i_rst     in   1        synchronous active-high reset             |
// |   mem       master        memory port (see param_acc_cpu_if)        |
// |   o_halted  out  1        core is in HALT                           |
// |   o_acc     out  DATA_W   accumulator (debug)                       |
// |   o_pc      out  ADDR_W   program counter (debug)                   |
// | Revision: 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module param_acc_cpu
  import cpu_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  param_acc_cpu_if.master     mem,
  output logic                o_halted,
  output logic [DATA_W-1:0]   o_acc,
  output logic [ADDR_W-1:0]   o_pc
);

  // The operand field sits below the opcode; a wider address cannot be
  // encoded in one instruction word.
  if (ADDR_W > DATA_W - OPC_W) begin : g_bad_addr_w
    $error("param_acc_cpu: ADDR_W (%0d) must not exceed DATA_W-4 (%0d)",
           ADDR_W, DATA_W - OPC_W);
  end

  state_e            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] ir, ir_n;
  logic [DATA_W-1:0] mdr, mdr_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic              z, z_n;
  logic              c, c_n;
  logic              acc_we;

  opcode_e           opc;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] imm;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;

  assign opc    = opcode_e'(ir[DATA_W-1 -: OPC_W]);
  assign opnd   = ir[ADDR_W-1:0];
  assign imm    = {{OPC_W{1'b0}}, ir[DATA_W-OPC_W-1:0]};
  assign alu_op = alu_op_of(opc);
  // DECODE works on the immediate (LDI) or on ACC alone; EXEC on MDR.
  assign alu_b  = (state == EXEC) ? mdr : imm;

  param_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (acc),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      mdr   <= '0;
      acc   <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      mdr   <= mdr_n;
      acc   <= acc_n;
      z     <= z_n;
      c     <= c_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    mdr_n   = mdr;
    acc_n   = acc;
    z_n     = z;
    c_n     = c;
    acc_we  = 1'b0;
    case (state)
      FETCH: begin
        if (mem.i_memReady) begin
          ir_n    = mem.i_memData;
          pc_n    = pc + ADDR_W'(1);
          state_n = DECODE;
        end
      end
      DECODE: begin
        state_n = FETCH;
        case (opc)
          OP_JMP: pc_n = opnd;
          OP_JZ:  if (z) pc_n = opnd;
          OP_JC:  if (c) pc_n = opnd;
          OP_LDI, OP_NOT, OP_SHL, OP_SHR: acc_we = 1'b1;
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_n = READ;
          OP_STORE: state_n = WRITE;
          OP_HALT:  state_n = HALT;
          default:  state_n = FETCH;
        endcase
      end
      READ: begin
        if (mem.i_memReady) begin
          mdr_n   = mem.i_memData;
          state_n = EXEC;
        end
      end
      EXEC: begin
        acc_we  = 1'b1;
        state_n = FETCH;
      end
      WRITE: begin
        if (mem.i_memReady) state_n = FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase

    if (acc_we) begin
      acc_n = alu_res;
      z_n   = alu_zero;
      // LOAD/LDI keep the carry from the previous arithmetic.
      if (alu_op != ALU_PASS) c_n = alu_carry;
    end
  end

  // Memory outputs depend only on state/registers and reset, never on ready.
  always_comb begin
    mem.o_memRdEnable = 1'b0;
    mem.o_memWrEnable = 1'b0;
    mem.o_memAddr     = '0;
    mem.o_memData     = '0;
    o_halted          = 1'b0;
    if (!i_rst) begin
      case (state)
        FETCH: begin
          mem.o_memRdEnable = 1'b1;
          mem.o_memAddr     = pc;
        end
        READ: begin
          mem.o_memRdEnable = 1'b1;
          mem.o_memAddr     = opnd;
        end
        WRITE: begin
          mem.o_memWrEnable = 1'b1;
          mem.o_memAddr     = opnd;
          mem.o_memData     = acc;
        end
        HALT:    o_halted = 1'b1;
        default: o_halted = 1'b0;
      endcase
    end
  end

  assign o_acc = acc;
  assign o_pc  = pc;

endmodule
`default_nettype wire
